// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: arbiter FSM state encoding and default bus widths.
//   arb_state_e    : 2-bit arbiter state (IDLE, BUSY_I, BUSY_D, RESP)
//   DEFAULT_ADDR_W : default memory address width in bits
//   DEFAULT_DATA_W : default memory data width in bits
package mem_arbiter_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 32;
    localparam int unsigned DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    // Saturating increment for the data-grant streak counter.
    function automatic logic [2:0] streak_inc(input logic [2:0] cur, input logic [2:0] max);
        return (cur >= max) ? max : cur + 3'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// requester (I) and a MEM-stage load/store requester (D).
// Data wins ties until it has been granted MAX_D_STREAK times in a row while
// the instruction side waits; then instruction is granted.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   i_req, i_addr                         instruction read request
//   i_rdata, i_ready                      fetched word, one-cycle done pulse
//   d_req, d_we, d_addr, d_wdata          data request (d_we=1 write)
//   d_rdata, d_ready                      load data, one-cycle done pulse
//   mem_req, mem_we, mem_addr, mem_wdata  registered memory command
//   mem_rdata, mem_ack                    memory read data and completion strobe
//   busy                                  high while a transaction is outstanding
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W       = DEFAULT_DATA_W,
    parameter int unsigned MAX_D_STREAK = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    localparam logic [2:0] MAX_S = 3'(MAX_D_STREAK);

    arb_state_e        state_q, state_d;
    logic [2:0]        streak_q, streak_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_req && ((streak_q < MAX_S) || !i_req)) begin
                    state_d     = ST_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    // Streak only counts while instruction is actually waiting.
                    streak_d    = i_req ? streak_inc(streak_q, MAX_S) : '0;
                end else if (i_req) begin
                    state_d     = ST_BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    streak_d    = '0;
                end
            end
            ST_BUSY_I: begin
                if (mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    i_rdata_d = mem_rdata;
                    i_ready_d = 1'b1;
                end
            end
            ST_BUSY_D: begin
                if (mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    // Stores complete without touching the load-data register.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_ready_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs are driven and outputs sampled
// on the falling clock edge; the DUT acts on the rising edge in between.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_D_STREAK (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_mem_req"},   64'(mem_req),   64'd0);
        check({tag, "_mem_we"},    64'(mem_we),    64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_i_ready"},   64'(i_ready),   64'd0);
        check({tag, "_d_ready"},   64'(d_ready),   64'd0);
        check({tag, "_i_rdata"},   64'(i_rdata),   64'd0);
        check({tag, "_d_rdata"},   64'(d_rdata),   64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    // Expected grant order with both requesters held: 1 = data, 0 = instruction.
    logic [5:0] grant_d_pattern;

    initial begin
        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check_idle_zero("reset");
        rst = 1'b0;

        // Instruction fetch, ack two cycles after mem_req rises.
        i_req  = 1'b1;
        i_addr = 32'h40;
        tick();
        check("if_mem_req",  64'(mem_req),  64'd1);
        check("if_mem_we",   64'(mem_we),   64'd0);
        check("if_mem_addr", 64'(mem_addr), 64'h40);
        check("if_busy",     64'(busy),     64'd1);
        i_req = 1'b0;
        tick();
        check("if_no_early_ready", 64'(i_ready), 64'd0);
        check("if_req_held",       64'(mem_req), 64'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h00500093;
        tick();
        mem_ack = 1'b0;
        check("if_i_ready",      64'(i_ready), 64'd1);
        check("if_i_rdata",      64'(i_rdata), 64'h00500093);
        check("if_mem_req_drop", 64'(mem_req), 64'd0);
        check("if_resp_busy",    64'(busy),    64'd1);
        tick();
        check("if_ready_pulse", 64'(i_ready), 64'd0);
        check("if_idle_busy",   64'(busy),    64'd0);
        check("if_rdata_hold",  64'(i_rdata), 64'h00500093);

        // Data load, ack one cycle after mem_req rises.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h200;
        tick();
        check("ld_mem_addr", 64'(mem_addr), 64'h200);
        check("ld_mem_we",   64'(mem_we),   64'd0);
        d_req     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        check("ld_d_ready", 64'(d_ready), 64'd1);
        check("ld_d_rdata", 64'(d_rdata), 64'hCAFEF00D);
        check("ld_i_ready", 64'(i_ready), 64'd0);
        tick();

        // Data store: d_rdata must keep the earlier load value.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h100;
        d_wdata = 32'hDEADBEEF;
        tick();
        check("st_mem_we",    64'(mem_we),    64'd1);
        check("st_mem_addr",  64'(mem_addr),  64'h100);
        check("st_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        check("st_d_ready",   64'(d_ready), 64'd1);
        check("st_d_rdata",   64'(d_rdata), 64'hCAFEF00D);
        tick();
        check("st_ready_pulse", 64'(d_ready), 64'd0);

        // Spurious ack in IDLE is ignored.
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ack = 1'b0;
        check("spur_i_ready", 64'(i_ready), 64'd0);
        check("spur_d_ready", 64'(d_ready), 64'd0);
        check("spur_busy",    64'(busy),    64'd0);
        check("spur_mem_req", 64'(mem_req), 64'd0);
        check("spur_d_rdata", 64'(d_rdata), 64'hCAFEF00D);

        // Request inputs changed mid-transaction must not leak to mem_*.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h300;
        tick();
        check("hold_addr0", 64'(mem_addr), 64'h300);
        d_addr  = 32'h3FC;
        d_we    = 1'b1;
        d_wdata = 32'h55;
        tick();
        check("hold_addr1", 64'(mem_addr),  64'h300);
        check("hold_we",    64'(mem_we),    64'd0);
        check("hold_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        check("hold_busy",  64'(busy),      64'd1);
        d_req     = 1'b0;
        d_we      = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        tick();
        mem_ack = 1'b0;
        check("hold_d_ready", 64'(d_ready), 64'd1);
        check("hold_d_rdata", 64'(d_rdata), 64'hA5A5A5A5);
        tick();

        // Both requesters held: grants D,D,I,D,D,I.
        grant_d_pattern = 6'b011011;
        i_req  = 1'b1;
        i_addr = 32'h40;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h80;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("grant%0d_addr", k), 64'(mem_addr),
                  grant_d_pattern[k] ? 64'h80 : 64'h40);
            mem_ack   = 1'b1;
            mem_rdata = 32'h1000 + 32'(k);
            tick();
            mem_ack = 1'b0;
            check($sformatf("grant%0d_d_ready", k), 64'(d_ready), 64'(grant_d_pattern[k]));
            check($sformatf("grant%0d_i_ready", k), 64'(i_ready), 64'(!grant_d_pattern[k]));
            if (grant_d_pattern[k])
                check($sformatf("grant%0d_d_rdata", k), 64'(d_rdata), 64'h1000 + 64'(k));
            else
                check($sformatf("grant%0d_i_rdata", k), 64'(i_rdata), 64'h1000 + 64'(k));
            tick();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        check("grant_end_idle", 64'(busy), 64'd0);

        // Reset while BUSY_D abandons the store; its late ack is ignored.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h500;
        d_wdata = 32'h77;
        tick();
        check("rst_busy_before", 64'(busy), 64'd1);
        d_req = 1'b0;
        d_we  = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("rst_mid");
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_ack = 1'b0;
        check("rst_late_d_ready", 64'(d_ready), 64'd0);
        check("rst_late_busy",    64'(busy),    64'd0);
        check("rst_late_d_rdata", 64'(d_rdata), 64'd0);
        i_req  = 1'b1;
        i_addr = 32'h44;
        tick();
        check("rst_if_mem_req",  64'(mem_req),  64'd1);
        check("rst_if_mem_addr", 64'(mem_addr), 64'h44);
        i_req     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h00A00113;
        tick();
        mem_ack = 1'b0;
        check("rst_if_i_ready", 64'(i_ready), 64'd1);
        check("rst_if_i_rdata", 64'(i_rdata), 64'h00A00113);
        tick();
        check("rst_if_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width in bits.
REQ-003 SHALL have parameter MAX_D_STREAK, default 2, maximum consecutive data grants while the instruction requester is waiting (range 1..7).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports i_req input 1, i_addr input ADDR_W: instruction-fetch read request and word address.
REQ-007 SHALL have ports i_rdata output DATA_W, i_ready output 1: fetched word, and a one-cycle completion pulse.
REQ-008 SHALL have ports d_req input 1, d_we input 1, d_addr input ADDR_W, d_wdata input DATA_W: MEM-stage request (d_we=1 write).
REQ-009 SHALL have ports d_rdata output DATA_W, d_ready output 1: load data, and a one-cycle completion pulse.
REQ-010 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W: single-port memory command.
REQ-011 SHALL have ports mem_rdata input DATA_W, mem_ack input 1: memory read data, and a completion strobe (variable latency, at least 1 cycle).
REQ-012 SHALL have port busy  output 1  high while a transaction is outstanding.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP.
REQ-014 IDLE: if d_req and (streak<MAX_D_STREAK or !i_req) go BUSY_D; else if i_req go BUSY_I; else stay.
REQ-015 On entering BUSY_x, SHALL register mem_req=1, mem_addr/mem_we/mem_wdata from the granted requester (mem_we=0 for instruction grants); these SHALL stay constant until mem_ack.
REQ-016 In BUSY_x on mem_ack: SHALL deassert mem_req the next cycle, capture mem_rdata into x_rdata (reads only; writes leave d_rdata unchanged), pulse x_ready for exactly one cycle, and go RESP.
REQ-017 RESP SHALL last one cycle (so requesters may drop/update req) and then return to IDLE; x_rdata SHALL hold its value until the next capture.
REQ-018 Latency: request sampled in IDLE at cycle N -> mem_req high at N+1; mem_ack at cycle M -> x_ready high at M+1; minimum 3 cycles request-to-ready.
REQ-019 Streak counter: increments on each data grant while i_req=1; clears on any instruction grant or when a data grant is made with i_req=0; saturates at MAX_D_STREAK.
REQ-020 Simultaneous i_req and d_req with streak<MAX_D_STREAK SHALL grant data; at streak==MAX_D_STREAK SHALL grant instruction.
REQ-021 mem_ack outside BUSY_I/BUSY_D SHALL be ignored.
REQ-022 A requester dropping req mid-transaction SHALL NOT abort the transaction; its ready still pulses.
REQ-023 Requester inputs sampled only in IDLE; changes during BUSY_x/RESP SHALL NOT affect mem_* outputs.
REQ-024 busy SHALL be 1 in BUSY_I, BUSY_D and RESP, 0 in IDLE.

Reset
REQ-025 rst high at a clock edge SHALL force IDLE, streak=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, busy=0.
REQ-026 Reset mid-transaction SHALL abandon it: no ready pulse, and any later mem_ack for it ignored.

Structure
REQ-027 FSM state encoding (2-bit) and the default ADDR_W/DATA_W constants SHALL live in the shared CPU package.
REQ-028 SHALL be a single module; no sub-module.

Verification
REQ-029 i_req only, addr 0x40, mem_ack 2 cycles after mem_req, rdata 0x00500093 -> mem_we=0, i_rdata=0x00500093, i_ready one-cycle pulse at ack+1.
REQ-030 d_req write addr 0x100 wdata 0xDEADBEEF -> mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, d_ready pulse, d_rdata unchanged.
REQ-031 i_req and d_req held continuously, MAX_D_STREAK=2 -> grant order D,D,I,D,D,I.
REQ-032 rst asserted while BUSY_D, then mem_ack -> no d_ready, all outputs zero, next i_req served normally.
REQ-033 Spurious mem_ack in IDLE, and d_addr changed during BUSY_D -> no ready pulse, no state change; mem_addr holds the originally latched address.
